// File: rtl/fpu_pkg.sv
// Shared FPU-side definitions.
// Holds the sequencer state encoding and the default WAIT timeout. The FPU
// datapath and other FPU-side blocks import this package as well.
package fpu_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWait    = 2'd2,
    StRespond = 2'd3
  } fpu_state_e;

  localparam int unsigned DefaultTimeoutCycles = 64;

endpackage

// File: rtl/fpu_req_fifo.sv
// In-order request FIFO for the FPU sequencer.
// Ports:
//   clock, reset      clock, asynchronous active-low reset
//   push, wdata       write an entry (ignored when full)
//   pop, rdata        read-ahead head entry; pop advances it (ignored when empty)
//   full, empty       occupancy flags derived from the registered count
//   count             number of stored entries
module fpu_req_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [width-1:0]             wdata,
  input  logic                         pop,
  output logic [width-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int unsigned PtrW   = $clog2(depth);
  localparam int unsigned CountW = $clog2(depth + 1);

  logic [width-1:0]  mem_q [depth];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CountW-1:0] count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CountW'(depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fpu_sequencer.sv
// Issue-side front end for the FPU.
// Queues requests, issues them one at a time to the FPU with a start pulse,
// waits for done (or a timeout) and returns the result in request order.
// Ports:
//   clock, reset                      clock, asynchronous active-low reset
//   req_*                             request valid/ready port with operands and command
//   rsp_*                             response valid/ready port; rsp_error flags a timeout
//   fpu_first/second/z/command        operands held stable from ISSUE through RESPOND
//   fpu_start                         one-cycle pulse in ISSUE
//   fpu_result, fpu_done              FPU result and level completion, sampled in WAIT only
//   busy                              operation in progress or requests queued
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned bitness        = 32,
  parameter int unsigned command_size   = 2,
  parameter int unsigned depth          = 4,
  parameter int unsigned timeout_cycles = DefaultTimeoutCycles
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [bitness-1:0]      req_first,
  input  logic [bitness-1:0]      req_second,
  input  logic [bitness-1:0]      req_z,
  input  logic [command_size-1:0] req_command,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [bitness-1:0]      rsp_result,
  output logic                    rsp_error,
  output logic [bitness-1:0]      fpu_first,
  output logic [bitness-1:0]      fpu_second,
  output logic [bitness-1:0]      fpu_z,
  output logic [command_size-1:0] fpu_command,
  output logic                    fpu_start,
  input  logic [bitness-1:0]      fpu_result,
  input  logic                    fpu_done,
  output logic                    busy
);

  localparam int unsigned CntW   = $clog2(timeout_cycles);
  localparam int unsigned CountW = $clog2(depth + 1);
  localparam int unsigned EntryW = 3 * bitness + command_size;

  fpu_state_e              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [bitness-1:0]      first_q, first_d, second_q, second_d, z_q, z_d;
  logic [command_size-1:0] command_q, command_d;
  logic [bitness-1:0]      result_q, result_d;
  logic                    error_q, error_d;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CountW-1:0]       fifo_count;
  logic [EntryW-1:0]       fifo_wdata, fifo_rdata;
  logic [bitness-1:0]      head_first, head_second, head_z;
  logic [command_size-1:0] head_command;

  assign fifo_wdata = {req_first, req_second, req_z, req_command};
  assign {head_first, head_second, head_z, head_command} = fifo_rdata;
  assign req_ready  = !fifo_full;
  assign fifo_push  = req_valid && !fifo_full;

  fpu_req_fifo #(
    .width (EntryW),
    .depth (depth)
  ) u_req_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    second_d  = second_q;
    z_d       = z_q;
    command_d = command_q;
    result_d  = result_q;
    error_d   = error_q;
    fifo_pop  = 1'b0;
    fpu_start = 1'b0;
    rsp_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          first_d   = head_first;
          second_d  = head_second;
          z_d       = head_z;
          command_d = head_command;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        fpu_start = 1'b1;
        cnt_d     = '0;
        state_d   = StWait;
      end
      StWait: begin
        // done takes priority over a timeout in the same cycle
        if (fpu_done) begin
          result_d = fpu_result;
          error_d  = 1'b0;
          state_d  = StRespond;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(timeout_cycles - 1)) begin
            result_d = '0;
            error_d  = 1'b1;
            state_d  = StRespond;
          end
        end
      end
      StRespond: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      first_q   <= '0;
      second_q  <= '0;
      z_q       <= '0;
      command_q <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      second_q  <= second_d;
      z_q       <= z_d;
      command_q <= command_d;
      result_q  <= result_d;
      error_q   <= error_d;
    end
  end

  assign fpu_first   = first_q;
  assign fpu_second  = second_q;
  assign fpu_z       = z_q;
  assign fpu_command = command_q;
  assign rsp_result  = result_q;
  assign rsp_error   = error_q;
  assign busy        = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer. The bench plays both the request
// producer and the FPU; a transaction-level model (queues of accepted and
// in-flight requests) predicts operands, results, ordering and latency.
module tb_fpu_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned T  = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_first = '0, req_second = '0, req_z = '0;
  logic [CW-1:0] req_command = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_result;
  logic          rsp_error;
  logic [W-1:0]  fpu_first, fpu_second, fpu_z;
  logic [CW-1:0] fpu_command;
  logic          fpu_start;
  logic [W-1:0]  fpu_result = '0;
  logic          fpu_done = 1'b0;
  logic          busy;

  fpu_sequencer #(
    .bitness        (W),
    .command_size   (CW),
    .depth          (D),
    .timeout_cycles (T)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_first   (req_first),
    .req_second  (req_second),
    .req_z       (req_z),
    .req_command (req_command),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_error   (rsp_error),
    .fpu_first   (fpu_first),
    .fpu_second  (fpu_second),
    .fpu_z       (fpu_z),
    .fpu_command (fpu_command),
    .fpu_start   (fpu_start),
    .fpu_result  (fpu_result),
    .fpu_done    (fpu_done),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // res: value the FPU returns; hang: FPU never completes;
  // delay: negedges after the observed start before done is raised.
  typedef struct {
    logic [W-1:0]  first;
    logic [W-1:0]  second;
    logic [W-1:0]  z;
    logic [W-1:0]  res;
    logic [CW-1:0] cmd;
    bit            hang;
    int            delay;
  } req_t;

  req_t req_q[$];   // waiting to be offered
  req_t exp_q[$];   // accepted, not yet issued
  req_t infl[$];    // issued, response not yet taken

  int checks = 0;
  int errors = 0;
  int cyc = 0, starts = 0, resps = 0;
  int cur_t0 = 0, done_at = 0;
  bit cur_seen = 1'b0, prev_start = 1'b0, stale = 1'b0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: never
  int push_prob = 100;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic [W-1:0] f, input logic [W-1:0] s,
                              input logic [W-1:0] z, input logic [W-1:0] res,
                              input logic [CW-1:0] c, input bit hang, input int delay);
    req_t r;
    r.first = f; r.second = s; r.z = z; r.res = res; r.cmd = c;
    r.hang = hang; r.delay = delay;
    return r;
  endfunction

  // Negedges from the observed start to the first observed rsp_valid: ISSUE,
  // at least one WAIT cycle, and done is only seen once it has been raised.
  function automatic int exp_lat(input req_t r);
    if (r.hang) return int'(T);
    return (r.delay + 1 > 2) ? r.delay + 1 : 2;
  endfunction

  // One environment step per falling edge: FPU model, response consumer, producer.
  task automatic env_step();
    req_t r;
    cyc++;
    if (!reset) begin
      req_valid  = 1'b0;
      rsp_ready  = 1'b0;
      fpu_done   = 1'b0;
      prev_start = 1'b0;
      return;
    end

    if (fpu_start) begin
      check("start_pulse", 64'(prev_start), 64'd0);
      check("one_outstanding", 64'(infl.size()), 64'd0);
      if (exp_q.size() == 0) begin
        check("start_without_req", 64'(fpu_start), 64'd0);
      end else begin
        r = exp_q.pop_front();
        check("fpu_first", fpu_first, r.first);
        check("fpu_second", fpu_second, r.second);
        check("fpu_z", fpu_z, r.z);
        check("fpu_command", fpu_command, r.cmd);
        infl.push_back(r);
        starts++;
        cur_t0     = cyc;
        cur_seen   = 1'b0;
        fpu_result = r.hang ? $urandom() : r.res;
        done_at    = cyc + r.delay;
      end
    end
    prev_start = fpu_start;

    if (infl.size() != 0 && !cur_seen) fpu_done = !infl[0].hang && (cyc >= done_at);
    else if (!stale) fpu_done = 1'b0;

    if (rsp_valid) begin
      if (infl.size() == 0) begin
        check("rsp_without_op", 64'(rsp_valid), 64'd0);
      end else begin
        if (!cur_seen) begin
          cur_seen = 1'b1;
          check("latency", 64'(cyc - cur_t0), 64'(exp_lat(infl[0])));
        end
        check("rsp_result", rsp_result, infl[0].hang ? '0 : infl[0].res);
        check("rsp_error", 64'(rsp_error), 64'(infl[0].hang));
        check("fpu_first_held", fpu_first, infl[0].first);
      end
    end

    case (ready_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 1) == 1);
      default: rsp_ready = 1'b0;
    endcase
    if (rsp_valid && rsp_ready && infl.size() != 0) begin
      void'(infl.pop_front());
      cur_seen = 1'b0;
      resps++;
    end

    // req_ready comes from the registered count, so it is final at this edge.
    if (req_q.size() != 0 && (push_prob >= 100 || $urandom_range(0, 99) < push_prob)) begin
      req_valid   = 1'b1;
      req_first   = req_q[0].first;
      req_second  = req_q[0].second;
      req_z       = req_q[0].z;
      req_command = req_q[0].cmd;
      if (req_ready) exp_q.push_back(req_q.pop_front());
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    env_step();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((req_q.size() + exp_q.size() + infl.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", 64'(req_q.size() + exp_q.size() + infl.size()), 64'd0);
    tick();
    tick();
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int s0, r0, n;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_rsp_error", 64'(rsp_error), 64'd0);
    check("rst_fpu_start", 64'(fpu_start), 64'd0);
    check("rst_fpu_ops", {fpu_first, fpu_second}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (2) tick();
    #2 reset = 1'b1;

    // Single operation, done two cycles after start.
    s0 = starts;
    req_q.push_back(mk(32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 2'd0, 1'b0, 2));
    drain(200);
    check("single_starts", 64'(starts - s0), 64'd1);

    // Fill with a slow FPU and a stalled consumer, then hold in RESPOND.
    s0 = starts; r0 = resps;
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      req_q.push_back(mk($urandom(), $urandom(), $urandom(), $urandom(),
                         CW'(i), 1'b0, 40));
    end
    repeat (12) tick();
    check("fill_ready", 64'(req_ready), 64'd0);
    check("fill_pending", 64'(req_q.size()), 64'd1);
    check("fill_busy", 64'(busy), 64'd1);
    n = 0;
    while (!cur_seen && n < 100) begin tick(); n++; end
    check("bp_reached_respond", 64'(cur_seen), 64'd1);
    repeat (10) tick();
    check("bp_no_new_start", 64'(starts - s0), 64'd1);
    check("bp_still_full", 64'(req_ready), 64'd0);
    ready_mode = 0;
    drain(1000);
    check("fill_resps", 64'(resps - r0), 64'd6);
    check("fill_starts", 64'(starts - s0), 64'd6);

    // Timeout followed by a normal operation.
    req_q.push_back(mk(32'h11111111, 32'h22222222, 32'h33333333, 32'hDEADBEEF, 2'd1, 1'b1, 0));
    req_q.push_back(mk(32'h44444444, 32'h55555555, 32'h66666666, 32'hCAFEF00D, 2'd2, 1'b0, 1));
    drain(400);

    // Done held high across two operations.
    stale = 1'b1;
    req_q.push_back(mk(32'hA0A0A0A0, 32'h0B0B0B0B, 32'h1, 32'h12345678, 2'd3, 1'b0, 0));
    req_q.push_back(mk(32'hC0C0C0C0, 32'h0D0D0D0D, 32'h2, 32'h9ABCDEF0, 2'd0, 1'b0, 0));
    drain(200);
    stale = 1'b0;

    // Reset during WAIT with two requests still queued.
    for (int i = 0; i < 3; i++) begin
      req_q.push_back(mk($urandom(), $urandom(), $urandom(), $urandom(),
                         CW'(i), 1'b0, 30));
    end
    n = 0;
    while (infl.size() == 0 && n < 50) begin tick(); n++; end
    repeat (4) tick();
    check("pre_reset_queued", 64'(exp_q.size()), 64'd2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_fpu_start", 64'(fpu_start), 64'd0);
    check("mid_rst_fpu_first", fpu_first, 64'd0);
    req_q.delete();
    exp_q.delete();
    infl.delete();
    cur_seen = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    s0 = starts;
    repeat (20) tick();
    check("post_rst_no_start", 64'(starts - s0), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    // Randomized traffic: gaps, random backpressure, occasional hangs.
    ready_mode = 1;
    push_prob  = 60;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) stale = ($urandom_range(0, 1) == 1);
      req_q.push_back(mk($urandom(), $urandom(), $urandom(), $urandom(),
                         CW'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
                         int'($urandom_range(0, 4))));
    end
    drain(6000);
    stale = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
